// File: rtl/cpu_controller.sv
// Moore control FSM sequencing the register transfers of each decoded RISC instruction.
// Optional CPU_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT instead of being treated as a NOP.
module cpu_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  output logic       waiting,
  output logic       done,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_CALC,
    S_WRITE_IMM,
    S_WRITE_C
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    ,
    S_HALT
`endif
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [2:0] r_opcode;
  logic [1:0] r_aluOp;

  logic       r_waiting;
  logic       r_done;
  logic [1:0] r_regSel;
  logic [1:0] r_wbSel;
  logic       r_wEn;
  logic       r_enA;
  logic       r_enB;
  logic       r_enC;
  logic       r_enStatus;
  logic       r_selA;

  logic       w_isMovImm;
  logic       w_isMovShift;
  logic       w_isAdd;
  logic       w_isCmp;
  logic       w_isAnd;
  logic       w_isMvn;

  assign w_isMovImm   = (r_opcode == 3'b110) && (r_aluOp == 2'b10);
  assign w_isMovShift = (r_opcode == 3'b110) && (r_aluOp == 2'b00);
  assign w_isAdd      = (r_opcode == 3'b101) && (r_aluOp == 2'b00);
  assign w_isCmp      = (r_opcode == 3'b101) && (r_aluOp == 2'b01);
  assign w_isAnd      = (r_opcode == 3'b101) && (r_aluOp == 2'b10);
  assign w_isMvn      = (r_opcode == 3'b101) && (r_aluOp == 2'b11);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_WAIT: begin
        if (start) w_nextState = S_DECODE;
      end
      S_DECODE: begin
        if (w_isMovImm)                        w_nextState = S_WRITE_IMM;
        else if (w_isMovShift || w_isMvn)      w_nextState = S_GET_B;
        else if (w_isAdd || w_isCmp || w_isAnd) w_nextState = S_GET_A;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        else                                   w_nextState = S_HALT;
`else
        else                                   w_nextState = S_WAIT;
`endif
      end
      S_GET_A:     w_nextState = S_GET_B;
      S_GET_B:     w_nextState = S_CALC;
      S_CALC:      w_nextState = w_isCmp ? S_WAIT : S_WRITE_C;
      S_WRITE_IMM: w_nextState = S_WAIT;
      S_WRITE_C:   w_nextState = S_WAIT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      S_HALT:      w_nextState = S_HALT;
`endif
      default:     w_nextState = S_WAIT;
    endcase
  end

  // Outputs are decoded from the upcoming state so they are registered yet still
  // line up with the state they belong to; the latched fields are stable past DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_WAIT;
      r_opcode   <= 3'b000;
      r_aluOp    <= 2'b00;
      r_waiting  <= 1'b1;
      r_done     <= 1'b0;
      r_regSel   <= 2'b00;
      r_wbSel    <= 2'b00;
      r_wEn      <= 1'b0;
      r_enA      <= 1'b0;
      r_enB      <= 1'b0;
      r_enC      <= 1'b0;
      r_enStatus <= 1'b0;
      r_selA     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == S_WAIT) && start) begin
        r_opcode <= opcode;
        r_aluOp  <= ALU_op;
      end
      r_waiting  <= 1'b0;
      r_done     <= 1'b0;
      r_regSel   <= 2'b00;
      r_wbSel    <= 2'b00;
      r_wEn      <= 1'b0;
      r_enA      <= 1'b0;
      r_enB      <= 1'b0;
      r_enC      <= 1'b0;
      r_enStatus <= 1'b0;
      r_selA     <= 1'b0;
      case (w_nextState)
        S_WAIT: r_waiting <= 1'b1;
        S_GET_A: begin
          r_regSel <= 2'b10;
          r_enA    <= 1'b1;
        end
        S_GET_B: r_enB <= 1'b1;
        S_CALC: begin
          if (w_isCmp) begin
            r_enStatus <= 1'b1;
            r_done     <= 1'b1;
          end else begin
            r_enC  <= 1'b1;
            r_selA <= w_isMovShift || w_isMvn;
          end
        end
        S_WRITE_IMM: begin
          r_regSel <= 2'b10;
          r_wbSel  <= 2'b10;
          r_wEn    <= 1'b1;
          r_done   <= 1'b1;
        end
        S_WRITE_C: begin
          r_regSel <= 2'b01;
          r_wbSel  <= 2'b00;
          r_wEn    <= 1'b1;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (reset) r_illegal <= 1'b0;
    else       r_illegal <= (w_nextState == S_HALT);
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign waiting   = r_waiting;
  assign done      = r_done;
  assign reg_sel   = r_regSel;
  assign wb_sel    = r_wbSel;
  assign w_en      = r_wEn;
  assign en_A      = r_enA;
  assign en_B      = r_enB;
  assign en_C      = r_enC;
  assign en_status = r_enStatus;
  assign sel_A     = r_selA;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: an instruction-level model expands each accepted
// instruction into its per-cycle control-word trace, and a monitor compares every cycle.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] ALU_op;
  logic       waiting;
  logic       done;
  logic [1:0] reg_sel;
  logic [1:0] wb_sel;
  logic       w_en;
  logic       en_A;
  logic       en_B;
  logic       en_C;
  logic       en_status;
  logic       sel_A;
  logic       illegal;

  cpu_controller dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .ALU_op    (ALU_op),
    .waiting   (waiting),
    .done      (done),
    .reg_sel   (reg_sel),
    .wb_sel    (wb_sel),
    .w_en      (w_en),
    .en_A      (en_A),
    .en_B      (en_B),
    .en_C      (en_C),
    .en_status (en_status),
    .sel_A     (sel_A),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef logic [12:0] vec_t;

  vec_t sb[$];
  vec_t trace[$];
  bit   busy = 1'b0;
  bit   halted = 1'b0;
  bit   pendingHalt = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   sampleNo = 0;

  // Control word layout: waiting done reg_sel wb_sel w_en en_A en_B en_C en_status sel_A illegal
  function automatic vec_t mk(input logic w, input logic d, input logic [1:0] rs,
                              input logic [1:0] ws, input logic we, input logic ea,
                              input logic eb, input logic ec, input logic es,
                              input logic sa, input logic il);
    return {w, d, rs, ws, we, ea, eb, ec, es, sa, il};
  endfunction

  // Expands one instruction into the sequence of register-transfer steps it performs.
  function automatic void loadTrace(input logic [2:0] op, input logic [1:0] a);
    vec_t fetchA;
    vec_t fetchB;
    vec_t writeC;
    fetchA = mk(0, 0, 2'b10, 2'b00, 0, 1, 0, 0, 0, 0, 0);
    fetchB = mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0);
    writeC = mk(0, 1, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0, 0);
    trace.delete();
    pendingHalt = 1'b0;
    trace.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    if (op == 3'b110 && a == 2'b10) begin
      trace.push_back(mk(0, 1, 2'b10, 2'b10, 1, 0, 0, 0, 0, 0, 0));
    end else if ((op == 3'b110 && a == 2'b00) || (op == 3'b101 && a == 2'b11)) begin
      trace.push_back(fetchB);
      trace.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0));
      trace.push_back(writeC);
    end else if (op == 3'b101 && a == 2'b01) begin
      trace.push_back(fetchA);
      trace.push_back(fetchB);
      trace.push_back(mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0));
    end else if (op == 3'b101) begin
      trace.push_back(fetchA);
      trace.push_back(fetchB);
      trace.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0));
      trace.push_back(writeC);
    end else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      pendingHalt = 1'b1;
`endif
    end
  endfunction

  // Drives one cycle of inputs, then predicts the control word for the cycle after the edge.
  task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [1:0] a,
                               input logic r);
    vec_t expv;
    start  = s;
    opcode = op;
    ALU_op = a;
    reset  = r;
    @(posedge clk);
    if (r) begin
      trace.delete();
      busy        = 1'b0;
      halted      = 1'b0;
      pendingHalt = 1'b0;
      expv        = mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    end else if (halted) begin
      expv = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    end else if (trace.size() > 0) begin
      expv = trace.pop_front();
    end else if (busy) begin
      busy = 1'b0;
      if (pendingHalt) begin
        halted      = 1'b1;
        pendingHalt = 1'b0;
        expv        = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
      end else begin
        expv = mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      end
    end else if (s) begin
      loadTrace(op, a);
      busy = 1'b1;
      expv = trace.pop_front();
    end else begin
      expv = mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    end
    #1;
    sb.push_back(expv);
  endtask

  task automatic checkOutput(input vec_t expv);
    vec_t got;
    got = {waiting, done, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, illegal};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL control_word sample %0d: got %b want %b (w d rs ws we A B C S selA ill)",
               sampleNo, got, expv);
    end
  endtask

  // Monitor: consumes one expected control word per cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        sampleNo++;
        checkOutput(sb.pop_front());
      end
    end
  end

  initial begin
    logic [2:0] legalOp[6];
    logic [1:0] legalAlu[6];
    logic [2:0] rOp;
    logic [1:0] rAlu;
    int         k;
    legalOp  = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101};
    legalAlu = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};

    $display("[TB] cpu_controller scoreboard bench starting");
    repeat (2) applyStimulus(0, 3'b000, 2'b00, 1);

    applyStimulus(1, 3'b110, 2'b10, 0);
    repeat (3) applyStimulus(0, 3'b000, 2'b00, 0);

    applyStimulus(1, 3'b101, 2'b00, 0);
    repeat (5) applyStimulus(0, 3'b000, 2'b00, 0);

    applyStimulus(1, 3'b101, 2'b01, 0);
    repeat (4) applyStimulus(0, 3'b110, 2'b10, 0);

    applyStimulus(1, 3'b101, 2'b11, 0);
    repeat (3) applyStimulus(1, 3'b110, 2'b10, 0);
    repeat (2) applyStimulus(0, 3'b000, 2'b00, 0);

    applyStimulus(1, 3'b110, 2'b00, 0);
    repeat (5) applyStimulus(0, 3'b000, 2'b00, 0);

    applyStimulus(1, 3'b101, 2'b00, 0);
    repeat (3) applyStimulus(0, 3'b000, 2'b00, 0);
    applyStimulus(1, 3'b101, 2'b00, 1);
    repeat (2) applyStimulus(0, 3'b000, 2'b00, 0);

    applyStimulus(1, 3'b011, 2'b00, 0);
    repeat (12) applyStimulus(1, 3'b101, 2'b00, 0);
    applyStimulus(0, 3'b000, 2'b00, 1);
    repeat (6) applyStimulus(0, 3'b000, 2'b00, 0);

    repeat (6) applyStimulus(1, 3'b110, 2'b10, 0);
    repeat (2) applyStimulus(0, 3'b000, 2'b00, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        k    = int'($urandom_range(0, 5));
        rOp  = legalOp[k];
        rAlu = legalAlu[k];
      end else begin
        rOp  = 3'($urandom_range(0, 7));
        rAlu = 2'($urandom_range(0, 3));
      end
      applyStimulus($urandom_range(0, 2) != 0, rOp, rAlu, $urandom_range(0, 63) == 0);
    end
    applyStimulus(0, 3'b000, 2'b00, 1);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
